// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver: start bit, N data bits LSB-first, optional parity, stop bit.
// The word is delivered on q with a one-cycle valid pulse and per-frame parity/framing flags.
module sipo_frame_rx #(
  parameter int N         = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter bit ODD       = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         SI,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         busy,
  output logic         parity_err,
  output logic         frame_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DATA  = 3'd1;
  localparam logic [2:0] PAR   = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  sr_reg;
  logic          perr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sr_reg     <= '0;
      perr_reg   <= 1'b0;
      q          <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // valid is a single-cycle pulse regardless of the strobe
      valid <= 1'b0;
      if (en) begin
        case (state_reg)
          IDLE: begin
            if (!SI) begin
              state_reg <= DATA;
              cnt_reg   <= '0;
            end
          end
          DATA: begin
            sr_reg  <= {SI, sr_reg[N-1:1]};
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(N - 1))
              state_reg <= PARITY_EN ? PAR : STOP;
          end
          PAR: begin
            perr_reg  <= (^sr_reg) ^ SI ^ ODD;
            state_reg <= STOP;
          end
          STOP: begin
            if (SI) begin
              q          <= sr_reg;
              valid      <= 1'b1;
              parity_err <= PARITY_EN ? perr_reg : 1'b0;
              frame_err  <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              // a low stop bit may be a line break; wait for the line to return high
              frame_err  <= 1'b1;
              parity_err <= 1'b0;
              state_reg  <= BREAK;
            end
          end
          BREAK: begin
            if (SI)
              state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench for sipo_frame_rx (N=4, even parity): stimulus pushes expected words,
// a monitor pops and compares on every valid pulse.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       si  = 1'b1;
  logic [3:0] q;
  logic       valid, busy, parity_err, frame_err;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  logic [5:0] exp_q[$];   // {q, parity_err, frame_err}
  int         vcyc[$];

  sipo_frame_rx #(.N(4), .PARITY_EN(1'b1), .ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .SI(si), .q(q), .valid(valid),
    .busy(busy), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // monitor: sample 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      if (valid === 1'b1) begin
        vcyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_valid: got q=0x%0h with no expected word (t=%0t)", q, $time);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          chk("q", q, e[5:2]);
          chk("parity_err", parity_err, e[1]);
          chk("frame_err", frame_err, e[0]);
          $display("valid: q=0x%0h perr=%0b ferr=%0b (expected q=0x%0h perr=%0b ferr=%0b)",
                   q, parity_err, frame_err, e[5:2], e[1], e[0]);
        end
      end
    end
  end

  // present one bit for one clock; optionally follow it with an en=0 cycle carrying garbage
  task automatic drive(input logic b, input logic gap);
    @(negedge clk);
    si = b; en = 1'b1;
    if (gap) begin
      @(negedge clk);
      si = ~b; en = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par, input logic stop, input logic gap);
    drive(1'b0, gap);
    for (int i = 0; i < 4; i++) drive(d[i], gap);
    drive(par, gap);
    drive(stop, gap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  initial begin
    // watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_q", q, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_parity_err", parity_err, 0);
    chk("reset_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // clean frame 4'hB, parity 1 (3 ones + 1 = even)
    exp_q.push_back({4'hB, 1'b0, 1'b0});
    send_frame(4'hB, 1'b1, 1'b1, 1'b0);
    @(negedge clk); si = 1'b1;
    chk("busy_after_clean", busy, 0);
    idle(2);

    // parity error: same data, parity 0
    exp_q.push_back({4'hB, 1'b1, 1'b0});
    send_frame(4'hB, 1'b0, 1'b1, 1'b0);
    idle(2);

    // framing error: 4'h5, parity 0, stop 0, then 3 low samples, then high
    send_frame(4'h5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ferr_set", frame_err, 1);
    chk("ferr_perr_clear", parity_err, 0);
    chk("ferr_q_hold", q, 4'hB);
    chk("ferr_busy", busy, 1);
    si = 1'b0; en = 1'b1;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    @(negedge clk);
    chk("break_busy", busy, 1);
    si = 1'b1;
    @(negedge clk);
    chk("break_exit_busy", busy, 0);
    chk("break_q_hold", q, 4'hB);
    idle(1);
    exp_q.push_back({4'h5, 1'b0, 1'b0});
    send_frame(4'h5, 1'b0, 1'b1, 1'b0);
    idle(2);

    // enable gaps: clean 4'hB with en alternating
    exp_q.push_back({4'hB, 1'b0, 1'b0});
    send_frame(4'hB, 1'b1, 1'b1, 1'b1);
    idle(2);

    // reset mid-frame after two data bits of 4'h6
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_q", q, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    @(negedge clk);
    rst = 1'b0; si = 1'b1; en = 1'b1;
    idle(1);
    exp_q.push_back({4'h6, 1'b0, 1'b0});
    send_frame(4'h6, 1'b0, 1'b1, 1'b0);
    idle(2);

    // back-to-back 4'h3 then 4'hC
    vcyc.delete();
    exp_q.push_back({4'h3, 1'b0, 1'b0});
    exp_q.push_back({4'hC, 1'b0, 1'b0});
    send_frame(4'h3, 1'b0, 1'b1, 1'b0);
    send_frame(4'hC, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("b2b_pulses", vcyc.size(), 2);
    if (vcyc.size() == 2) chk("b2b_spacing", vcyc[1] - vcyc[0], 7);

    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-in/parallel-out frame receiver; receiving end of the team's parallel-load/serial-out shift register link.
- Samples SI on clock-enable strobes and detects a start bit.
- Shifts in N data bits LSB-first, then checks an optional parity bit and the stop bit.
- Presents the word on q with a one-cycle valid pulse and error flags; sits between a serial source and word-level consumer logic.

Parameters:
- N, 4, data bits per frame (N >= 2).
- PARITY_EN, 1, 1 = parity bit follows data; 0 = no parity bit.
- ODD, 0, 0 = even parity (data ones plus parity bit is even); 1 = odd.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bit strobe; SI is sampled only on rising edges where en=1.
- SI  input  1  serial line; idles at 1.
- q  output  N  last accepted word.
- valid  output  1  one-cycle pulse when q is updated.
- busy  output  1  high in any state other than IDLE.
- parity_err  output  1  parity result of the last completed frame.
- frame_err  output  1  stop-bit result of the last completed frame.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All state is registered on the rising edge of clk.
- Reset values: q=0, valid=0, busy=0, parity_err=0, frame_err=0, state=IDLE, bit counter=0, shift register=0. Reset takes effect immediately, including mid-frame, with no edge required.
- en=0: state, counter, shift register and flags hold. valid is still forced low on the edge after its pulse.
- States: IDLE, DATA, PAR, STOP, BREAK.
- IDLE:
  - Sample SI=0 -> DATA, counter=0.
  - Sample SI=1 -> stay in IDLE.
- DATA:
  - Each sample shifts right: SI enters the MSB, so the first data bit ends up in bit 0.
  - Counter increments; after the Nth sample, go to PAR if PARITY_EN=1, else STOP.
  - Counter width is $clog2(N).
- PAR: store the computed error = (XOR of data bits) XOR SI XOR ODD, then go to STOP.
- STOP, on the sample edge:
  - SI=1: q <= shift register, valid=1 for exactly one cycle, parity_err <= stored error (0 if PARITY_EN=0), frame_err <= 0. Go to IDLE.
  - SI=0: q holds, valid stays 0, frame_err <= 1, parity_err <= 0. Go to BREAK.
- BREAK: stay until a sample with SI=1, then go to IDLE. A held-low line is never taken as a new start bit.
- Parity error does not suppress delivery: q is updated and valid pulses with parity_err=1.
- parity_err and frame_err are held until the next frame completes at STOP.
- Latency: valid is high in the cycle following the stop-bit sample edge.
- Back-to-back: a start bit sampled in the cycle right after the stop sample is accepted. Minimum frame is N+3 samples with parity, N+2 without.

Test Plan:
- Clean frame, en=1 every cycle, N=4, even parity: SI = 0,1,1,0,1,1,1 (start, data 4'hB LSB-first, parity 1, stop) -> valid pulses once one cycle after the stop sample; q=4'hB, parity_err=0, frame_err=0, busy falls to 0.
- Parity error: same frame with parity bit 0 -> valid pulses, q=4'hB, parity_err=1.
- Framing error plus recovery: frame 4'h5 with stop=0, then SI=0 for 3 samples, then 1 -> no valid, q stays at its previous value, frame_err=1, busy=1 until SI=1 is sampled. A following clean 4'h5 frame gives q=4'h5 and frame_err=0.
- Enable gaps: the clean 4'hB frame with en alternating 1/0 -> same outputs as the first scenario; nothing changes on en=0 edges.
- Reset mid-operation: assert rst after 2 data bits, between clock edges -> q=0, busy=0, valid=0 immediately. After release, frame 4'h6 is received correctly.
- Back-to-back: frames 4'h3 then 4'hC with en=1 every cycle and no idle gap -> two valid pulses 7 cycles apart; q=4'h3, then 4'hC.
